// File: rtl/q2_sequencer.sv
// Two-phase instruction sequencer: each state spends one settle clock (ws=0) and
// one write clock (ws=1), with run/step halt control parked in FETCH.
module q2_sequencer (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic step,
   input  logic deref,
   input  logic o0,
   input  logic o1,
   input  logic o2,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic ws,
   output logic halted,
   output logic alu_last
);

   typedef enum logic [3:0] {
      FETCH = 4'd0,  DEREF = 4'd1,  LOAD = 4'd2,  EXEC = 4'd3,
      ALU0  = 4'd4,  ALU1  = 4'd5,  ALU2 = 4'd6,  ALU3 = 4'd7,
      ALU4  = 4'd8,  ALU5  = 4'd9,  ALU6 = 4'd10, ALU7 = 4'd11
   } state_e;

   logic [3:0] state_q, state_d, succ;
   logic       ws_q, ws_d;
   logic       halted_q, halted_d;
   logic       pend_q, pend_d;
   logic       alu_op;

   assign alu_op = o2 & (o0 | o1);

   // Successor of the current state, used only on the edge ending ws=1.
   always_comb begin
      succ = FETCH;
      case (state_q)
         FETCH:   succ = deref ? DEREF : LOAD;
         DEREF:   succ = LOAD;
         LOAD:    succ = EXEC;
         EXEC:    succ = alu_op ? ALU0 : FETCH;
         ALU0, ALU1, ALU2, ALU3, ALU4, ALU5, ALU6:
                  succ = state_q + 4'd1;
         default: succ = FETCH;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      ws_d     = ws_q;
      halted_d = halted_q;
      pend_d   = pend_q;
      if (state_q > ALU7) begin
         state_d  = FETCH;
         ws_d     = 1'b0;
         halted_d = ~run & ~pend_q;
      end else if (halted_q) begin
         if (step)
            pend_d = 1'b1;
         if (run | step | pend_q)
            halted_d = 1'b0;
      end else if (!ws_q) begin
         ws_d = 1'b1;
      end else begin
         ws_d    = 1'b0;
         state_d = succ;
         if (state_q == FETCH)
            pend_d = 1'b0;
         // Entering FETCH is the only point where a dropped run takes effect.
         if (succ == FETCH)
            halted_d = ~run;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         ws_q     <= 1'b0;
         halted_q <= 1'b1;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ws_q     <= ws_d;
         halted_q <= halted_d;
         pend_q   <= pend_d;
      end
   end

   assign {s3, s2, s1, s0} = state_q;
   assign ws               = ws_q;
   assign halted           = halted_q;
   assign alu_last         = (state_q == ALU7);

endmodule

// File: doc/q2_sequencer.md
Q2_SEQUENCER -- requirements
Module: q2_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: run  input  1  level; 1 = free-run instructions, 0 = halt at next instruction boundary.
REQ-004 SHALL have port: step  input  1  debounced single-cycle pulse; requests one instruction while halted.
REQ-005 SHALL have port: deref  input  1  current instruction needs indirect operand fetch.
REQ-006 SHALL have port: o0, o1, o2  input  1 each  latched opcode bits.
REQ-007 SHALL have ports: s0, s1, s2, s3  output  1 each  machine state bits; state = {s3,s2,s1,s0}.
REQ-008 SHALL have port: ws  output  1  write strobe; 0 = settle phase, 1 = write phase.
REQ-009 SHALL have port: halted  output  1  machine parked in FETCH settle phase.
REQ-010 SHALL have port: alu_last  output  1  high during final ALU shift state.

Function
REQ-011 State encodings SHALL be: FETCH 0000, DEREF 0001, LOAD 0010, EXEC 0011, ALU0..ALU7 0100..1011; 1100..1111 illegal.
REQ-012 Every state SHALL last exactly two clocks: first with ws=0, second with ws=1; the state bits change only on the edge ending the ws=1 clock.
REQ-013 ws SHALL toggle every clock while not halted and SHALL stay 0 while halted.
REQ-014 FETCH SHALL transition to DEREF if deref=1, else to LOAD; deref SHALL be sampled on the edge ending FETCH's ws=1 clock.
REQ-015 DEREF SHALL transition to LOAD.
REQ-016 LOAD SHALL transition to EXEC.
REQ-017 EXEC SHALL transition to ALU0 when alu_op = o2 & (o0 | o1) is 1, else to FETCH; opcode bits SHALL be sampled on the edge ending EXEC's ws=1 clock.
REQ-018 ALUn SHALL transition to ALU(n+1) for n = 0..6; ALU7 SHALL transition to FETCH (exactly 8 shift states, 16 clocks).
REQ-019 alu_last SHALL be 1 only in ALU7 (both phases), 0 otherwise.
REQ-020 Halt rule: on entry to FETCH (and while parked there), if run=0 and no step is pending, the sequencer SHALL park with state 0000, ws=0, halted=1.
REQ-021 A step pulse arriving while halted SHALL set a one-bit pending flag; the next clock SHALL leave park (halted=0, ws begins toggling); the flag SHALL clear when FETCH's ws=1 phase completes, and the machine SHALL park again at the following FETCH if run=0.
REQ-022 step pulses while not halted SHALL be ignored (no pending flag set).
REQ-023 run rising while halted SHALL unpark on the next clock; run falling mid-instruction SHALL NOT abort it: the instruction SHALL complete and park at the next FETCH.
REQ-024 Illegal states (1100..1111) SHALL transition to FETCH with ws=0 on the next clock.
REQ-025 Opcode/deref changes in any clock other than their sampling edge SHALL have no effect on sequencing.

Reset
REQ-026 While rst=1 on a clock edge: state SHALL become 0000, ws=0, halted=1, pending step flag=0, alu_last=0; rst SHALL take priority over all other inputs, including mid-instruction and mid-ALU.
REQ-027 After rst deasserts the machine SHALL remain halted until run=1 or a step pulse.

Verification
REQ-028 Reset then run=1, deref=0, o2..o0=000: states 0000,0010,0011,0000 each 2 clocks, ws pattern 0,1 repeating, halted=0 from the first clock after run rises.
REQ-029 run=1, deref=1, opcode 101: 0000,0001,0010,0011, then ALU0..ALU7 (0100..1011), alu_last=1 only in the 2 clocks of 1011, then 0000; total 24 clocks.
REQ-030 Halted, run=0, one step pulse, opcode 000, deref=0: exactly one FETCH-LOAD-EXEC pass (6 clocks), then parked in 0000 with halted=1, ws=0; a second step during that pass is ignored.
REQ-031 run=1, drop run=0 in ALU3: ALU4..ALU7 complete, then park in 0000, halted=1.
REQ-032 Assert rst during ALU5 ws=1: next clock state=0000, ws=0, halted=1, alu_last=0.
REQ-033 Force illegal state 1110 (bench-forced): next clock state=0000, ws=0.
